// File: rtl/pulse_generator.sv
// pulse_generator: stretches a one-cycle trigger into a level lasting 'width' clk_en ticks,
// with optional delay, hold-off and retrigger. Define PULSE_GENERATOR_STATS_EN for pulse/drop counters.
module pulse_generator #(
  parameter int PULSE_LEVEL   = 1,
  parameter int CNT_W         = 8,
  parameter int DELAY_TICKS   = 0,
  parameter int HOLDOFF_TICKS = 0,
  parameter int RETRIGGER     = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             trigger,
  input  logic [CNT_W-1:0] width,
  output logic             out,
  output logic             busy,
  output logic             dropped
`ifdef PULSE_GENERATOR_STATS_EN
  ,
  output logic [15:0]      pulse_count,
  output logic [15:0]      drop_count
`endif
);

  if (DELAY_TICKS < 0 || longint'(DELAY_TICKS) >= (longint'(1) << CNT_W)) begin : g_bad_delay
    $error("pulse_generator: DELAY_TICKS does not fit in CNT_W bits");
  end
  if (HOLDOFF_TICKS < 0 || longint'(HOLDOFF_TICKS) >= (longint'(1) << CNT_W)) begin : g_bad_holdoff
    $error("pulse_generator: HOLDOFF_TICKS does not fit in CNT_W bits");
  end

  localparam logic             ACT_LVL  = (PULSE_LEVEL != 0);
  localparam logic             IDLE_LVL = (PULSE_LEVEL == 0);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] DLY_C    = CNT_W'(DELAY_TICKS);
  localparam logic [CNT_W-1:0] HLD_C    = CNT_W'(HOLDOFF_TICKS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DELAY   = 2'd1,
    S_ACTIVE  = 2'd2,
    S_HOLDOFF = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] wlat_q, wlat_d;
  logic             out_q, out_d;
  logic             busy_q, busy_d;
  logic             drop_q, drop_d;
  logic             last_tick;
  logic             width_ok;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wlat_d    = wlat_q;
    out_d     = out_q;
    drop_d    = 1'b0;
    // The final tick of a phase is the edge where the counter expires; nothing may extend it.
    last_tick = clk_en && (cnt_q == ONE);
    width_ok  = (width != '0);

    case (state_q)
      S_IDLE: begin
        if (trigger) begin
          if (width_ok) begin
            wlat_d = width;
            if (DELAY_TICKS > 0) begin
              state_d = S_DELAY;
              cnt_d   = DLY_C;
            end else begin
              state_d = S_ACTIVE;
              cnt_d   = width;
              out_d   = ACT_LVL;
            end
          end else begin
            drop_d = 1'b1;
          end
        end
      end

      S_DELAY: begin
        drop_d = trigger;
        if (clk_en) begin
          if (cnt_q == ONE) begin
            state_d = S_ACTIVE;
            cnt_d   = wlat_q;
            out_d   = ACT_LVL;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
      end

      S_ACTIVE: begin
        if ((RETRIGGER != 0) && trigger && width_ok && !last_tick) begin
          cnt_d  = width;
          wlat_d = width;
        end else begin
          drop_d = trigger;
          if (clk_en) begin
            if (cnt_q == ONE) begin
              out_d = IDLE_LVL;
              if (HOLDOFF_TICKS > 0) begin
                state_d = S_HOLDOFF;
                cnt_d   = HLD_C;
              end else begin
                state_d = S_IDLE;
                cnt_d   = '0;
              end
            end else begin
              cnt_d = cnt_q - ONE;
            end
          end
        end
      end

      S_HOLDOFF: begin
        drop_d = trigger;
        if (clk_en) begin
          if (cnt_q == ONE) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        out_d   = IDLE_LVL;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wlat_q  <= '0;
      out_q   <= IDLE_LVL;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wlat_q  <= wlat_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
    end
  end

  assign out     = out_q;
  assign busy    = busy_q;
  assign dropped = drop_q;

`ifdef PULSE_GENERATOR_STATS_EN
  logic [15:0] pcnt_q, pcnt_d;
  logic [15:0] dcnt_q, dcnt_d;

  // Counters move on the same edge that registers the ACTIVE entry or the drop strobe.
  always_comb begin
    pcnt_d = pcnt_q;
    dcnt_d = dcnt_q;
    if ((state_d == S_ACTIVE) && (state_q != S_ACTIVE) && (pcnt_q != 16'hFFFF)) begin
      pcnt_d = pcnt_q + 16'd1;
    end
    if (drop_d && (dcnt_q != 16'hFFFF)) begin
      dcnt_d = dcnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_q <= '0;
      dcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
      dcnt_q <= dcnt_d;
    end
  end

  assign pulse_count = pcnt_q;
  assign drop_count  = dcnt_q;
`endif

endmodule
